// File: rtl/i2c_slave_if.sv
// I2C slave front end: synchronizes SCL/SDA, decodes START/STOP, answers SLAVE_ADDRESS and moves bytes to/from a host.
// Latency: bus edges reach the FSM 2 cycles after the pins change; host pulses are registered (1 more cycle).
// Backpressure: the host cannot stall writes; reads stall by holding SCL low only when I2C_SLAVE_CLK_STRETCH_EN is defined.
module i2c_slave_if #(
   parameter int                        I2C_ADDR_WIDTH = 7,
   parameter int                        I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = 7'h22
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      scl_o,
   output logic                      sda_o,
   output logic                      xfer_start_o,
   output logic                      xfer_rw_o,
   output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
   output logic                      wr_valid_o,
   output logic                      rd_req_o,
   input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
   input  logic                      rd_valid_i,
   output logic                      xfer_done_o,
   output logic [I2C_ADDR_WIDTH-1:0] mon_addr_o,
   output logic                      busy_o
);

   localparam int            CW       = $clog2(I2C_DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(I2C_DATA_WIDTH);
   localparam int            MSB      = I2C_DATA_WIDTH - 1;

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t                    state_q;
   logic [I2C_DATA_WIDTH-1:0] shift_q;
   logic [CW-1:0]             bit_cnt_q;
   logic                      sda_q, start_q, rw_q, wr_valid_q, rd_req_q, done_q, busy_q;
   logic                      active_q, load_pend_q;
   logic [I2C_DATA_WIDTH-1:0] wr_data_q;
   logic [I2C_ADDR_WIDTH-1:0] mon_addr_q;
   logic                      scl_s1_q, scl_s2_q, scl_prev_q;
   logic                      sda_s1_q, sda_s2_q, sda_prev_q;

   logic scl_rise, scl_fall, start_det, stop_det, addr_match;

   // Two-flop synchronizers plus one history stage; reset to the idle (released) bus level so no edge is seen on exit.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         {scl_s1_q, scl_s2_q, scl_prev_q} <= 3'b111;
         {sda_s1_q, sda_s2_q, sda_prev_q} <= 3'b111;
      end else begin
         {scl_s1_q, scl_s2_q, scl_prev_q} <= {scl_i, scl_s1_q, scl_s2_q};
         {sda_s1_q, sda_s2_q, sda_prev_q} <= {sda_i, sda_s1_q, sda_s2_q};
      end
   end

   // SCL must be high on both sides of the SDA edge, so an SDA change coinciding with an SCL release is data, not START/STOP.
   assign scl_rise   = scl_s2_q & ~scl_prev_q;
   assign scl_fall   = ~scl_s2_q & scl_prev_q;
   assign start_det  = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
   assign stop_det   = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
   assign addr_match = (shift_q[MSB -: I2C_ADDR_WIDTH] == SLAVE_ADDRESS);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
   logic scl_q;
   assign scl_o = scl_q;
`else
   logic unused_rd_valid;
   assign unused_rd_valid = rd_valid_i;
   assign scl_o           = 1'b1;
`endif

   // Protocol FSM: START/STOP override every state; bits sampled on SCL rise, SDA changed only after SCL fall.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         sda_q       <= 1'b1;
         start_q     <= 1'b0;
         rw_q        <= 1'b0;
         wr_data_q   <= '0;
         wr_valid_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         done_q      <= 1'b0;
         mon_addr_q  <= '0;
         busy_q      <= 1'b0;
         active_q    <= 1'b0;
         load_pend_q <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
         scl_q       <= 1'b1;
`endif
      end else begin
         start_q    <= 1'b0;
         wr_valid_q <= 1'b0;
         rd_req_q   <= 1'b0;
         done_q     <= 1'b0;
         if (start_det || stop_det) begin
            // active_q marks an ACKed transfer, so a NACKed address never reports done
            done_q      <= active_q;
            active_q    <= 1'b0;
            busy_q      <= start_det;
            state_q     <= start_det ? ADDR : IDLE;
            bit_cnt_q   <= '0;
            sda_q       <= 1'b1;
            load_pend_q <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_q       <= 1'b1;
`endif
         end else begin
            case (state_q)
               ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[MSB-1:0], sda_s2_q};
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     if (addr_match) begin
                        sda_q      <= 1'b0;
                        start_q    <= 1'b1;
                        rw_q       <= shift_q[0];
                        mon_addr_q <= shift_q[MSB -: I2C_ADDR_WIDTH];
                        active_q   <= 1'b1;
                        state_q    <= ADDR_ACK;
                     end else begin
                        state_q    <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     sda_q <= 1'b1;
                     if (rw_q) begin
                        rd_req_q    <= 1'b1;
                        load_pend_q <= 1'b1;
                        state_q     <= RD_DATA;
                     end else begin
                        state_q     <= WR_DATA;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[MSB-1:0], sda_s2_q};
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
                     wr_data_q  <= shift_q;
                     wr_valid_q <= 1'b1;
                     sda_q      <= 1'b0;
                     bit_cnt_q  <= '0;
                     state_q    <= WR_ACK;
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_q   <= 1'b1;
                     state_q <= WR_DATA;
                  end
               end
               RD_DATA: begin
                  // load_pend_q is high exactly while rd_req_o is asserted (or while stretching)
                  if (load_pend_q) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                     if (rd_valid_i) begin
                        shift_q     <= rd_data_i;
                        sda_q       <= rd_data_i[MSB];
                        load_pend_q <= 1'b0;
                        scl_q       <= 1'b1;
                     end else begin
                        scl_q       <= 1'b0;
                     end
`else
                     shift_q     <= rd_data_i;
                     sda_q       <= rd_data_i[MSB];
                     load_pend_q <= 1'b0;
`endif
                  end else if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end else if (scl_fall) begin
                     if (bit_cnt_q == LAST_BIT) begin
                        sda_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= RD_ACK;
                     end else begin
                        shift_q   <= {shift_q[MSB-1:0], 1'b0};
                        sda_q     <= shift_q[MSB-1];
                     end
                  end
               end
               RD_ACK: begin
                  // NACK ends the read on the rising edge; otherwise the following fall starts the next byte
                  if (scl_rise && sda_s2_q) begin
                     state_q <= IGNORE;
                  end else if (scl_fall) begin
                     rd_req_q    <= 1'b1;
                     load_pend_q <= 1'b1;
                     state_q     <= RD_DATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_o        = sda_q;
   assign xfer_start_o = start_q;
   assign xfer_rw_o    = rw_q;
   assign wr_data_o    = wr_data_q;
   assign wr_valid_o   = wr_valid_q;
   assign rd_req_o     = rd_req_q;
   assign xfer_done_o  = done_q;
   assign mon_addr_o   = mon_addr_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: a bit-banged I2C master on an open-drain bus model plus a pulse monitor.
// Host read data is pre-staged as rd_base + number of rd_req pulses seen so far.
// Every comparison goes through check_val and feeds the summary counters.
module tb_i2c_slave_if;

   localparam int Q = 4;  // quarter SCL period in system clocks

   logic       clk = 1'b0;
   logic       rst_n, scl_m, sda_m, rd_valid;
   logic [7:0] rd_base;
   logic       scl_o, sda_o, xfer_start_o, xfer_rw_o, wr_valid_o, rd_req_o, xfer_done_o, busy_o;
   logic [7:0] wr_data_o, rd_data;
   logic [6:0] mon_addr_o;
   logic       scl_bus, sda_bus;

   int         n_start = 0, n_wr = 0, n_rd = 0, n_done = 0, n_sdalow = 0;
   logic       last_rw = 1'b0;
   logic [7:0] last_wr = 8'h00;
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   assign scl_bus = scl_m & scl_o;
   assign sda_bus = sda_m & sda_o;
   assign rd_data = rd_base + n_rd[7:0];

   i2c_slave_if dut (
      .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
      .scl_o(scl_o), .sda_o(sda_o), .xfer_start_o(xfer_start_o), .xfer_rw_o(xfer_rw_o),
      .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .rd_req_o(rd_req_o),
      .rd_data_i(rd_data), .rd_valid_i(rd_valid), .xfer_done_o(xfer_done_o),
      .mon_addr_o(mon_addr_o), .busy_o(busy_o)
   );

   always @(posedge clk) begin
      if (xfer_start_o) begin n_start <= n_start + 1; last_rw <= xfer_rw_o; end
      if (wr_valid_o)   begin n_wr <= n_wr + 1; last_wr <= wr_data_o; end
      if (rd_req_o)     n_rd <= n_rd + 1;
      if (xfer_done_o)  n_done <= n_done + 1;
      if (!sda_o)       n_sdalow <= n_sdalow + 1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected summary");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, output logic rb);
      int n;
      wt(Q); sda_m = b; wt(Q); scl_m = 1'b1;
      n = 0;
      while (scl_bus !== 1'b1 && n < 500) begin wt(1); n++; end
      if (n >= 500) check_val("scl_release", 32'(scl_bus), 32'd1);
      wt(Q); rb = sda_bus; wt(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      wt(Q); sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q); sda_m = 1'b0; wt(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wt(Q); sda_m = 1'b0; wt(Q); scl_m = 1'b1; wt(Q); sda_m = 1'b1; wt(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic x;
      for (int i = 7; i >= 0; i--) send_bit(b[i], x);
      send_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] b);
      logic x;
      for (int i = 7; i >= 0; i--) begin send_bit(1'b1, x); b[i] = x; end
      send_bit(nack, x);
   endtask

   initial begin
      int s_start, s_wr, s_rd, s_done, s_low, nacks;
      logic ack;
      logic [7:0] b, v;
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rd_valid = 1'b1; rd_base = 8'd0;
      wt(5);
      check_val("rst_lines", {scl_o, sda_o}, 2'b11);
      check_val("rst_pulses", {xfer_start_o, wr_valid_o, rd_req_o, xfer_done_o, busy_o}, 5'b0);
      check_val("rst_regs", {wr_data_o, mon_addr_o, xfer_rw_o}, 16'h0);
      rst_n = 1'b1; wt(5);

      // write 0x00..0x1F to 0x22
      s_start = n_start; s_wr = n_wr; s_done = n_done; nacks = 0;
      i2c_start();
      check_val("wr_busy", busy_o, 1'b1);
      wr_byte(8'h44, ack); nacks += int'(ack);
      check_val("wr_xfer_start", n_start - s_start, 1);
      check_val("wr_rw", last_rw, 1'b0);
      for (int i = 0; i < 32; i++) begin
         wr_byte(8'(i), ack); nacks += int'(ack);
         check_val("wr_data", last_wr, i);
      end
      i2c_stop(); wt(4);
      check_val("wr_nacks", nacks, 0);
      check_val("wr_valid_cnt", n_wr - s_wr, 32);
      check_val("wr_done_cnt", n_done - s_done, 1);
      check_val("wr_mon_addr", mon_addr_o, 7'h22);
      check_val("wr_busy_after", busy_o, 1'b0);

      // read 32 bytes starting at 100
      s_rd = n_rd; s_done = n_done;
      rd_base = 8'd100 - n_rd[7:0];
      i2c_start(); wr_byte(8'h45, ack);
      check_val("rd_addr_ack", ack, 1'b0);
      check_val("rd_rw", last_rw, 1'b1);
      for (int i = 0; i < 32; i++) begin
         rd_byte(i == 31, b);
         check_val("rd_data", b, 100 + i);
      end
      i2c_stop(); wt(4);
      check_val("rd_req_cnt", n_rd - s_rd, 32);
      check_val("rd_done_cnt", n_done - s_done, 1);

      // address 0x23 is not ours
      s_start = n_start; s_wr = n_wr; s_done = n_done; s_low = n_sdalow;
      i2c_start(); wr_byte(8'h46, ack); i2c_stop(); wt(4);
      check_val("mm_nack", ack, 1'b1);
      check_val("mm_sda_low", n_sdalow - s_low, 0);
      check_val("mm_events", (n_start - s_start) + (n_wr - s_wr) + (n_done - s_done), 0);

      // alternating single-byte write / read with changing values
      for (int i = 0; i < 16; i++) begin
         v = 8'h40 + 8'(3 * i);
         s_done = n_done; nacks = 0;
         i2c_start(); wr_byte(8'h44, ack); nacks += int'(ack);
         wr_byte(v, ack); nacks += int'(ack); i2c_stop(); wt(2);
         check_val("alt_wr_data", last_wr, v);
         rd_base = 8'h3F - 8'(i) - n_rd[7:0];
         i2c_start(); wr_byte(8'h45, ack); nacks += int'(ack);
         rd_byte(1'b1, b); i2c_stop(); wt(2);
         check_val("alt_rd_data", b, 8'h3F - 8'(i));
         check_val("alt_done_cnt", n_done - s_done, 2);
         check_val("alt_nacks", nacks, 0);
      end

      // repeated START after a write byte, then a read
      s_start = n_start; s_done = n_done;
      rd_base = 8'h9C - n_rd[7:0];
      i2c_start(); wr_byte(8'h44, ack); wr_byte(8'h77, ack);
      i2c_start(); wt(2);
      check_val("rs_done_write", n_done - s_done, 1);
      wr_byte(8'h45, ack);
      check_val("rs_start_cnt", n_start - s_start, 2);
      check_val("rs_rw", last_rw, 1'b1);
      rd_byte(1'b1, b); i2c_stop(); wt(4);
      check_val("rs_rd_data", b, 8'h9C);
      check_val("rs_done_cnt", n_done - s_done, 2);

      // reset in the middle of a read byte
      s_done = n_done;
      i2c_start(); wr_byte(8'h45, ack);
      for (int i = 0; i < 3; i++) send_bit(1'b1, ack);
      rst_n = 1'b0; wt(3);
      check_val("mid_rst_lines", {scl_o, sda_o, busy_o}, 3'b110);
      check_val("mid_rst_regs", {wr_data_o, mon_addr_o, xfer_rw_o}, 16'h0);
      check_val("mid_rst_done", n_done - s_done, 0);
      rst_n = 1'b1; wt(Q); sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(8);
      check_val("post_rst_done", n_done - s_done, 0);
      nacks = 0;
      i2c_start(); wr_byte(8'h44, ack); nacks += int'(ack);
      wr_byte(8'h55, ack); nacks += int'(ack); i2c_stop(); wt(4);
      check_val("post_rst_nacks", nacks, 0);
      check_val("post_rst_wr_data", wr_data_o, 8'h55);
      check_val("post_rst_done_cnt", n_done - s_done, 1);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
      begin
         int low_cnt;
         rd_valid = 1'b0;
         rd_base  = 8'hA5 - n_rd[7:0];
         i2c_start(); wr_byte(8'h45, ack);
         wt(6); low_cnt = 0;
         for (int i = 0; i < 50; i++) begin
            if (!scl_o) low_cnt++;
            wt(1);
         end
         rd_valid = 1'b1;
         check_val("stretch_low_cycles", low_cnt, 50);
         rd_byte(1'b1, b); i2c_stop(); wt(4);
         check_val("stretch_rd_data", b, 8'hA5);
         check_val("stretch_scl_released", scl_o, 1'b1);
      end
`endif

      wt(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
